// File: rtl/eth_tx_arbiter_if.sv
// Requester and TX-FIFO side signals of the Ethernet TX arbiter.
// The arbiter connects to the slave modport; the frame sources and MAC wrapper use the master modport.
interface eth_tx_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int LEN_W = 11
);
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*LEN_W-1:0] i_len;
  logic [N_REQ*8-1:0]     i_data;
  logic [N_REQ-1:0]       o_rd;
  logic [N_REQ-1:0]       o_grant;
  logic [N_REQ-1:0]       o_done;
  logic                   o_err;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;

  modport slave (
    input  i_req, i_len, i_data, i_tx_ready,
    output o_rd, o_grant, o_done, o_err, o_tx_data, o_tx_valid
  );

  modport master (
    output i_req, i_len, i_data, i_tx_ready,
    input  o_rd, o_grant, o_done, o_err, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing the Ethernet TX byte path between N_REQ frame sources,
// one whole frame per grant, followed by a hold-off and a wait for the MAC to go idle.
module eth_tx_arbiter #(
  parameter int N_REQ    = 2,
  parameter int LEN_W    = 11,
  parameter int MAX_LEN  = 1500,
  parameter int HOLDOFF  = 8,
  parameter int DRAIN_TO = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  eth_tx_arbiter_if.slave   bus
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WAIT_W = $clog2(HOLDOFF + DRAIN_TO + 1);

  localparam logic [LEN_W-1:0]  MAX_V   = LEN_W'(MAX_LEN);
  localparam logic [WAIT_W-1:0] HOLD_V  = WAIT_W'(HOLDOFF);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(HOLDOFF + DRAIN_TO - 1);
  localparam logic [IDX_W-1:0]  LAST_IX = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE     = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  sel_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [WAIT_W-1:0] wait_q;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  done_q;
  logic              err_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;

  logic              sel_found_d;
  logic [IDX_W-1:0]  sel_d;
  logic [LEN_W-1:0]  len_raw_d;
  logic [LEN_W-1:0]  len_d;
  logic [IDX_W-1:0]  rr_next_d;

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    int c;
    c           = 0;
    sel_found_d = 1'b0;
    sel_d       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = int'(rr_ptr_q) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (!sel_found_d && bus.i_req[c]) begin
        sel_found_d = 1'b1;
        sel_d       = IDX_W'(c);
      end
    end
  end

  assign len_raw_d = bus.i_len[sel_d*LEN_W +: LEN_W];
  assign len_d     = (len_raw_d > MAX_V) ? MAX_V : len_raw_d;
  assign rr_next_d = (sel_q == LAST_IX) ? '0 : sel_q + IDX_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      case (state_q)
        // No grant in the o_done cycle: the finishing source may still hold its request.
        IDLE: begin
          if (bus.i_tx_ready && sel_found_d && (done_q == '0)) begin
            sel_q   <= sel_d;
            grant_q <= ONE << sel_d;
            len_q   <= len_d;
            count_q <= '0;
            wait_q  <= '0;
            state_q <= (len_d == '0) ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          tx_data_q  <= bus.i_data[sel_q*8 +: 8];
          tx_valid_q <= 1'b1;
          if (count_q == len_q - LEN_W'(1)) begin
            count_q <= '0;
            wait_q  <= '0;
            state_q <= DRAIN;
          end else begin
            count_q <= count_q + LEN_W'(1);
          end
        end
        // Ready is ignored for HOLDOFF cycles, then awaited for up to DRAIN_TO cycles.
        DRAIN: begin
          if (wait_q < HOLD_V) begin
            wait_q <= wait_q + WAIT_W'(1);
          end else if (bus.i_tx_ready || (wait_q == TO_LAST)) begin
            done_q   <= grant_q;
            err_q    <= !bus.i_tx_ready;
            grant_q  <= '0;
            rr_ptr_q <= rr_next_d;
            state_q  <= IDLE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_rd       = (state_q == STREAM) ? grant_q : '0;
  assign bus.o_grant    = grant_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_valid = tx_valid_q;
endmodule
